mem_txn_server: RTL and testbench
=================================

MEM_TXN_SERVER -- requirements
Module: mem_txn_server

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in local store.
REQ-002 Parameter LATENCY, default 2, edges from request sample to response edge; legal range 1..15.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_start  input  1  transaction request from matrix engine; sampled only in IDLE.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_wdata  input  32  write data.
REQ-009 rsp_done  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  32  read data, valid while rsp_done is high.
REQ-011 rsp_err  output  1  error flag, valid while rsp_done is high.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 host_we  input  1  host preload write strobe.
REQ-014 host_addr  input  $clog2(DEPTH)  host word index.
REQ-015 host_wdata  input  32  host write data.

Function
REQ-016 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE: req_start=1 at edge k -> capture addr/we/wdata; load latency counter with LATENCY-1; go to WAIT, or to RESP directly when LATENCY=1.
REQ-018 WAIT: decrement counter each edge; at count 1 go to RESP.
REQ-019 rsp_done SHALL be registered high for exactly the cycle between edges k+LATENCY and k+LATENCY+1; all other cycles low.
REQ-020 Word index = addr[31:2]; request is erroneous if addr[1:0]!=0 or addr[31:2]>=DEPTH.
REQ-021 Valid read: rsp_rdata = store[index] as of the response edge (pre-edge contents); rsp_err=0.
REQ-022 Valid write: store[index] <= wdata on response edge; rsp_rdata=0; rsp_err=0.
REQ-023 Erroneous request: no store update; rsp_rdata=0; rsp_err=1.
REQ-024 rsp_rdata and rsp_err SHALL be 0 whenever rsp_done is 0.
REQ-025 RESP returns to IDLE at the next edge; a new request is sampled no earlier than that edge (one idle cycle minimum between transactions).
REQ-026 req_start while busy SHALL be ignored; not queued.
REQ-027 host_we writes store[host_addr] on any edge, any state; host_addr>=DEPTH is ignored.
REQ-028 Host and engine writes to same word on same edge: engine write wins; different words: both commit.
REQ-029 Host write on the response edge of a read to the same word: read returns pre-edge value.

Reset
REQ-030 rst asserted: state=IDLE, counter=0, rsp_done=0, rsp_rdata=0, rsp_err=0, busy=0, immediately (asynchronous).
REQ-031 Reset mid-transaction: the in-flight transaction is abandoned; no rsp_done and no store write.
REQ-032 Store contents are not reset.

Structure
REQ-033 Package mem_txn_pkg holds the state encoding, data width (32), and DEPTH/LATENCY defaults.
REQ-034 One sub-module, mem_txn_ram: DEPTH x 32, two synchronous write ports with engine-priority, one asynchronous read port.

Verification
REQ-035 Host preloads word 3=0x0000_1234; engine reads addr 0x0C at edge k -> rsp_done at k+2, rsp_rdata=0x0000_1234, rsp_err=0.
REQ-036 Engine writes 0xDEAD_BEEF to 0x10, then reads 0x10 -> second response returns 0xDEAD_BEEF; busy high for exactly 2 cycles per transaction.
REQ-037 Read addr 0x0000_0102 (misaligned) and 0x100 (index 64) -> rsp_err=1, rsp_rdata=0, store unchanged.
REQ-038 Host and engine both write word 5 on the same edge (0x1111 vs 0x2222) -> word 5=0x2222.
REQ-039 rst pulsed in WAIT after a write to 0x08 -> no rsp_done, word 2 unchanged, busy=0 immediately.
REQ-040 req_start held high continuously, LATENCY=1 -> rsp_done every 2nd cycle, no lost or duplicated pulses.

Source files
------------

// File: rtl/mem_txn_pkg.sv
// Shared types and defaults for the memory transaction server.
package mem_txn_pkg;

  localparam int DATA_W      = 32;
  localparam int DEPTH_DEF   = 64;
  localparam int LATENCY_DEF = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_txn_ram.sv
// DEPTH x 32 local store: engine and host write ports (engine wins on a shared
// word), one combinational read port.
module mem_txn_ram
  import mem_txn_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              eng_we,
  input  logic [AW-1:0]     eng_idx,
  input  logic [DATA_W-1:0] eng_wdata,
  input  logic              host_we,
  input  logic [AW-1:0]     host_idx,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              host_ok;

  // Host indices beyond DEPTH only exist when DEPTH is not a power of two.
  if (DEPTH == (1 << AW)) begin : g_full
    assign host_ok = 1'b1;
  end else begin : g_part
    assign host_ok = ({{(32-AW){1'b0}}, host_idx} < DEPTH);
  end

  always_ff @(posedge clk) begin
    if (host_we && host_ok && !(eng_we && (eng_idx == host_idx)))
      mem[host_idx] <= host_wdata;
    if (eng_we)
      mem[eng_idx] <= eng_wdata;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_txn_server.sv
// Single-outstanding memory transaction server with fixed response latency.
// state | meaning
// IDLE  | waiting for req_start; request fields captured on accept
// WAIT  | latency countdown, RESP entered when count reaches 1
// RESP  | next edge commits the write / samples read data and pulses rsp_done
module mem_txn_server
  import mem_txn_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_start,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_wdata
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              capture, fire, err, eng_we;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (req_start) begin
          capture   = 1'b1;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))
          state_nxt = RESP;
      end
      RESP: begin
        fire      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (capture) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
    end
  end

  assign err    = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
  assign eng_we = fire && we_q && !err;
  assign busy   = (state != IDLE);

  // Response fields are registered so they are zero outside the rsp_done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_done  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_done  <= fire;
      rsp_err   <= fire && err;
      rsp_rdata <= (fire && !we_q && !err) ? rd_data : '0;
    end
  end

  mem_txn_ram #(.DEPTH(DEPTH)) u_ram (
    .clk        (clk),
    .eng_we     (eng_we),
    .eng_idx    (addr_q[AW+1:2]),
    .eng_wdata  (wdata_q),
    .host_we    (host_we),
    .host_idx   (host_addr),
    .host_wdata (host_wdata),
    .rd_idx     (addr_q[AW+1:2]),
    .rd_data    (rd_data)
  );

endmodule

// File: tb/tb_mem_txn_server.sv
// Directed bench for mem_txn_server with a response scoreboard and store model.
module tb_mem_txn_server;
  import mem_txn_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_start = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_done, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;

  logic        req_start1 = 1'b0;
  logic        rsp_done1, rsp_err1, busy1;
  logic [31:0] rsp_rdata1;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mdl [64];
  logic [32:0] sb_q [$];
  logic [32:0] sb_e;

  always #5 clk = ~clk;

  mem_txn_server #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata)
  );

  mem_txn_server #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_start(req_start1), .req_addr(32'h0000_0000), .req_we(1'b1),
    .req_wdata(32'h0000_0001), .rsp_done(rsp_done1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .busy(busy1), .host_we(1'b0), .host_addr(6'd0), .host_wdata(32'h0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", {31'b0, rsp_done}, 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata, sb_e[31:0]);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, sb_e[32]});
        end
      end else begin
        chk("idle_rdata", rsp_rdata, 32'd0);
        chk("idle_err", {31'b0, rsp_err}, 32'd0);
      end
    end
  end

  task automatic host_wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic hwe, input logic [5:0] haddr, input logic [31:0] hdata,
                        input bit hold);
    logic        err;
    logic [31:0] exp_rd;
    err    = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
    exp_rd = (we || err) ? 32'd0 : mdl[addr[7:2]];
    sb_q.push_back({err, exp_rd});
    @(negedge clk);
    req_start = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata;
    @(posedge clk); #1;
    chk("busy_k", {31'b0, busy}, 32'd1);
    chk("done_k", {31'b0, rsp_done}, 32'd0);
    if (hold) begin
      req_addr = 32'h0000_000C; req_we = 1'b1; req_wdata = 32'hBAD0_BAD0;
    end else begin
      req_start = 1'b0;
    end
    @(posedge clk); #1;
    chk("busy_k1", {31'b0, busy}, 32'd1);
    chk("done_k1", {31'b0, rsp_done}, 32'd0);
    host_we = hwe; host_addr = haddr; host_wdata = hdata;
    @(posedge clk); #1;
    chk("busy_k2", {31'b0, busy}, 32'd0);
    chk("done_k2", {31'b0, rsp_done}, 32'd1);
    host_we = 1'b0; req_start = 1'b0;
    if (hwe) mdl[haddr] = hdata;
    if (we && !err) mdl[addr[7:2]] = wdata;
  endtask

  initial begin
    int pulses;
    #2 rst = 1'b1;
    #1;
    chk("rst_done", {31'b0, rsp_done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk); rst = 1'b0;

    host_wr(6'd3, 32'h0000_1234);
    do_txn(32'h0C, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
    do_txn(32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'd0, 32'h0, 1'b0);
    do_txn(32'h10, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);

    host_wr(6'd0, 32'hAAAA_0000);
    do_txn(32'h102, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
    do_txn(32'h100, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
    do_txn(32'h100, 1'b1, 32'h7777, 1'b0, 6'd0, 32'h0, 1'b0);
    do_txn(32'h11, 1'b1, 32'h5555, 1'b0, 6'd0, 32'h0, 1'b0);
    do_txn(32'h00, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
    do_txn(32'h10, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);

    do_txn(32'h14, 1'b1, 32'h2222, 1'b1, 6'd5, 32'h1111, 1'b0);
    do_txn(32'h14, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);

    host_wr(6'd6, 32'h0000_6666);
    do_txn(32'h18, 1'b0, 32'h0, 1'b1, 6'd6, 32'h0000_6060, 1'b0);
    do_txn(32'h18, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);

    do_txn(32'h1C, 1'b1, 32'h0000_0007, 1'b1, 6'd8, 32'h0000_0008, 1'b0);
    do_txn(32'h1C, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
    do_txn(32'h20, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);

    do_txn(32'h0C, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1);
    do_txn(32'h0C, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);

    // Abandon a write to word 2 while it sits in WAIT.
    host_wr(6'd2, 32'h0000_0002);
    @(negedge clk);
    req_start = 1'b1; req_addr = 32'h08; req_we = 1'b1; req_wdata = 32'h0000_9999;
    @(posedge clk); #1;
    req_start = 1'b0;
    chk("wait_busy", {31'b0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_done", {31'b0, rsp_done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_done", {31'b0, rsp_done}, 32'd0);
    end
    do_txn(32'h08, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);

    // LATENCY=1 instance with req_start held high.
    pulses = 0;
    @(negedge clk); req_start1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("lat1_done", {31'b0, rsp_done1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("lat1_busy", {31'b0, busy1}, (i % 2 == 1) ? 32'd0 : 32'd1);
      if (rsp_done1) begin
        pulses++;
        chk("lat1_err", {31'b0, rsp_err1}, 32'd0);
        chk("lat1_rdata", rsp_rdata1, 32'd0);
      end
    end
    req_start1 = 1'b0;
    chk("lat1_pulses", pulses, 32'd10);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
